// File: rtl/robread_commit_buffer_pkg.sv
// Shared ROB read-entry payload and the solo-entry classifier used by the commit buffer.
package robread_commit_buffer_pkg;

    localparam int unsigned ROB_XLEN  = 64;
    localparam int unsigned ROB_ITAGW = 8;
    localparam int unsigned ROB_REGW  = 5;
    localparam int unsigned ROB_CSRW  = 12;
    localparam int unsigned ROB_OPCW  = 7;
    localparam int unsigned ROB_FFLW  = 5;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } robread_brtype_e;

    typedef struct packed {
        logic [ROB_XLEN-1:0]  data;
        logic [ROB_XLEN-1:0]  csrdata;
        logic [ROB_XLEN-1:0]  branchaddr;
        logic [ROB_XLEN-1:0]  pc;
        logic                 jump;
        logic [ROB_FFLW-1:0]  fflag;
        logic                 mmio;
        logic                 ld_addr_misalign;
        logic                 ld_access_fault;
        logic                 ld_page_fault;
        logic                 st_addr_misalign;
        logic                 st_access_fault;
        logic                 st_page_fault;
        logic                 ins_addr_misalign;
        logic                 ins_access_fault;
        logic                 ins_page_fault;
        logic [ROB_OPCW-1:0]  opcode;
        logic                 mret;
        logic                 sret;
        logic                 illins;
        logic                 ecall;
        logic                 ebreak;
        logic                 irrevo;
        logic [ROB_REGW-1:0]  rd_index;
        logic                 rd_en;
        logic [ROB_REGW-1:0]  frd_index;
        logic                 frd_en;
        logic [ROB_CSRW-1:0]  csr_index;
        logic                 csr_en;
        logic                 fflagen;
        robread_brtype_e      branchtype;
        logic [ROB_ITAGW-1:0] itag;
        logic                 complete;
    } robread_entry_t;

    // An entry that traps, changes privilege or touches side-effecting state must retire alone.
    function automatic logic robread_is_solo(input robread_entry_t e);
        logic fault;
        fault = e.ld_addr_misalign | e.ld_access_fault | e.ld_page_fault
              | e.st_addr_misalign | e.st_access_fault | e.st_page_fault
              | e.ins_addr_misalign | e.ins_access_fault | e.ins_page_fault;
        return fault | e.illins | e.ecall | e.ebreak | e.mret | e.sret | e.irrevo | e.mmio;
    endfunction

endpackage

// File: rtl/robread_commit_buffer_lane_mask.sv
// Builds the contiguous retire mask from per-lane present/complete/solo flags, lane 0 oldest.
module robread_lane_mask #(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0] present,
    input  logic [LANES-1:0] complete,
    input  logic [LANES-1:0] solo,
    output logic [LANES-1:0] valid
);

    logic run;

    // A solo head blocks every younger lane; a solo younger lane blocks itself and beyond.
    always_comb begin
        valid    = '0;
        run      = present[0] && complete[0];
        valid[0] = run;
        for (int k = 1; k < LANES; k++) begin
            run      = run && present[k] && complete[k] && !solo[k] && !solo[0];
            valid[k] = run;
        end
    end

endmodule

// File: rtl/robread_commit_buffer.sv
// Multi-lane ROB read buffer feeding in-order commit, with writeback completion and solo retirement.
// Optional commit stall counter enabled by defining ROBREAD_STALL_CNT_EN.
module robread_commit_buffer
    import robread_commit_buffer_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ITAGW = ROB_ITAGW
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic                                 flush_i,
    input  logic [LANES-1:0]                     in_valid_i,
    input  logic [LANES*$bits(robread_entry_t)-1:0] in_entry_i,
    output logic                                 in_ready_o,
    input  logic                                 wb_valid_i,
    input  logic [ITAGW-1:0]                     wb_itag_i,
    output logic [LANES-1:0]                     out_valid_o,
    output logic [LANES*$bits(robread_entry_t)-1:0] out_entry_o,
    input  logic [$clog2(LANES+1)-1:0]           out_pop_i,
    output logic [63:0]                          stall_cnt_o
);

    localparam int unsigned EW   = $bits(robread_entry_t);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned POPW = $clog2(LANES + 1);

    robread_entry_t   mem [DEPTH];
    logic [DEPTH-1:0] done_q, done_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    robread_entry_t   in_e  [LANES];
    logic [PTRW-1:0]  wslot [LANES];
    logic [PTRW-1:0]  rslot [LANES];
    logic [LANES-1:0] push_lane;
    logic [POPW-1:0]  push_n;
    logic             push;

    logic [DEPTH-1:0] live, wb_hit;
    logic [PTRW-1:0]  slot_off;

    robread_entry_t   out_tmp;
    logic [LANES-1:0] lane_present, lane_done, lane_solo;

    assign in_ready_o = (cnt_q <= CNTW'(DEPTH - LANES)) && !flush_i;
    assign push       = in_valid_i[0] && in_ready_o;

    // Per-lane unpacking and slot addressing; lanes land/read at consecutive slots mod DEPTH.
    always_comb begin
        push_lane = '0;
        push_n    = '0;
        for (int k = 0; k < LANES; k++) begin
            in_e[k]      = robread_entry_t'(in_entry_i[k*EW +: EW]);
            wslot[k]     = wr_ptr_q + PTRW'(k);
            rslot[k]     = rd_ptr_q + PTRW'(k);
            push_lane[k] = push && in_valid_i[k];
            push_n       = push_n + POPW'(push_lane[k]);
        end
    end

    // Only occupied slots may match a writeback; stale tags in freed slots are ignored.
    always_comb begin
        live     = '0;
        wb_hit   = '0;
        slot_off = '0;
        for (int s = 0; s < DEPTH; s++) begin
            slot_off  = PTRW'(s) - rd_ptr_q;
            live[s]   = CNTW'(slot_off) < cnt_q;
            wb_hit[s] = wb_valid_i && live[s] && (ITAGW'(mem[s].itag) == wb_itag_i);
        end
    end

    // Next state: writeback, then free popped slots, then seed pushed slots; flush overrides all.
    always_comb begin
        done_d   = done_q | wb_hit;
        rd_ptr_d = rd_ptr_q + PTRW'(out_pop_i);
        wr_ptr_d = wr_ptr_q + PTRW'(push_n);
        cnt_d    = cnt_q + CNTW'(push_n) - CNTW'(out_pop_i);
        for (int k = 0; k < LANES; k++) begin
            if (POPW'(k) < out_pop_i) begin
                done_d[rslot[k]] = 1'b0;
            end
            if (push_lane[k]) begin
                done_d[wslot[k]] = in_e[k].complete
                                 || (wb_valid_i && (ITAGW'(in_e[k].itag) == wb_itag_i));
            end
        end
        if (flush_i) begin
            done_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            done_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q   <= done_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; visibility is governed by cnt and the complete bits.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANES; k++) begin
            if (push_lane[k]) begin
                mem[wslot[k]] <= in_e[k];
            end
        end
    end

    always_comb begin
        out_entry_o  = '0;
        out_tmp      = '0;
        lane_present = '0;
        lane_done    = '0;
        lane_solo    = '0;
        for (int k = 0; k < LANES; k++) begin
            out_tmp                  = mem[rslot[k]];
            out_tmp.complete         = done_q[rslot[k]];
            out_entry_o[k*EW +: EW]  = out_tmp;
            lane_present[k]          = CNTW'(k) < cnt_q;
            lane_done[k]             = done_q[rslot[k]];
            lane_solo[k]             = robread_is_solo(mem[rslot[k]]);
        end
    end

    robread_lane_mask #(
        .LANES (LANES)
    ) u_lane_mask (
        .present  (lane_present),
        .complete (lane_done),
        .solo     (lane_solo),
        .valid    (out_valid_o)
    );

`ifdef ROBREAD_STALL_CNT_EN
    logic [63:0] stall_q;

    // Counts cycles where something is buffered but the head cannot retire; saturates.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stall_q <= '0;
        end else if ((cnt_q != '0) && !out_valid_o[0] && (stall_q != '1)) begin
            stall_q <= stall_q + 64'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    a_in_valid_contiguous: assert property (@(posedge clk_i) disable iff (arst_i)
        (in_valid_i & (in_valid_i + LANES'(1))) == '0);

    a_pop_within_valid: assert property (@(posedge clk_i) disable iff (arst_i)
        out_pop_i <= POPW'($countones(out_valid_o)));

endmodule

// File: tb/tb_robread_commit_buffer.sv
// Bench for robread_commit_buffer: directed vector table, stall-counter sequence and random traffic
// against a queue model. Stall expectations follow ROBREAD_STALL_CNT_EN.
module tb_robread_commit_buffer;
    import robread_commit_buffer_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned ITAGW = 8;
    localparam int unsigned EW    = $bits(robread_entry_t);

    logic                  clk_i;
    logic                  arst_i;
    logic                  flush_i;
    logic [LANES-1:0]      in_valid_i;
    logic [LANES*EW-1:0]   in_entry_i;
    logic                  in_ready_o;
    logic                  wb_valid_i;
    logic [ITAGW-1:0]      wb_itag_i;
    logic [LANES-1:0]      out_valid_o;
    logic [LANES*EW-1:0]   out_entry_o;
    logic [1:0]            out_pop_i;
    logic [63:0]           stall_cnt_o;

    robread_commit_buffer #(.LANES(LANES), .DEPTH(DEPTH), .ITAGW(ITAGW)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_entry_i  (in_entry_i),
        .in_ready_o  (in_ready_o),
        .wb_valid_i  (wb_valid_i),
        .wb_itag_i   (wb_itag_i),
        .out_valid_o (out_valid_o),
        .out_entry_o (out_entry_o),
        .out_pop_i   (out_pop_i),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    localparam int K_NONE  = 0;
    localparam int K_ECALL = 1;
    localparam int K_MMIO  = 2;

    typedef struct {
        logic [7:0]  itag;
        logic [63:0] data;
        bit          done;
        bit          solo;
    } mdl_t;

    typedef struct {
        logic [1:0] inv;
        int         t0, k0;
        bit         c0;
        int         t1, k1;
        bit         c1;
        logic       wbv;
        logic [7:0] wbt;
        logic [1:0] pop;
        logic       fl;
        logic [1:0] ev;
        logic       er;
    } vec_t;

    mdl_t           q[$];
    vec_t           tbl[$];
    logic [63:0]    m_stall;
    robread_entry_t st_e [2];
    bit             st_solo [2];
    logic           tbl_chk;
    logic [1:0]     tbl_ev;
    logic           tbl_er;
    int             n_tests;
    int             n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_stall();
`ifdef ROBREAD_STALL_CNT_EN
        return m_stall;
`else
        return 64'd0;
`endif
    endfunction

    // Retire-ready lanes straight from the rules: oldest first, stop at the first blocker.
    function automatic logic [1:0] model_valid();
        logic [1:0] v;
        v = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (k >= q.size()) break;
            if (!q[k].done) break;
            if (k > 0 && (q[k].solo || q[0].solo)) break;
            v[k] = 1'b1;
            if (k == 0 && q[0].solo) break;
        end
        return v;
    endfunction

    task automatic mk(input int lane, input logic [7:0] tag, input int kind, input bit c);
        robread_entry_t e;
        e            = '0;
        e.data       = {$urandom, $urandom};
        e.pc         = {32'h0, $urandom};
        e.opcode     = 7'h33;
        e.branchtype = BR_NONE;
        e.itag       = tag;
        e.complete   = c;
        case (kind)
            1:  e.ecall             = 1'b1;
            2:  e.mmio              = 1'b1;
            3:  e.ebreak            = 1'b1;
            4:  e.mret              = 1'b1;
            5:  e.sret              = 1'b1;
            6:  e.illins            = 1'b1;
            7:  e.irrevo            = 1'b1;
            8:  e.ld_page_fault     = 1'b1;
            9:  e.st_access_fault   = 1'b1;
            10: e.ins_addr_misalign = 1'b1;
            default: ;
        endcase
        st_e[lane]    = e;
        st_solo[lane] = (kind != K_NONE);
    endtask

    // One clock: drive, compare at the falling edge, then advance the model at the rising edge.
    task automatic cyc(input logic [1:0] inv, input logic wbv, input logic [7:0] wbt,
                       input logic [1:0] pop, input logic fl);
        logic [1:0]     ev;
        logic           er;
        int             sz;
        robread_entry_t oe;
        mdl_t           r;
        in_valid_i = inv;
        in_entry_i = {st_e[1], st_e[0]};
        wb_valid_i = wbv;
        wb_itag_i  = wbt;
        out_pop_i  = pop;
        flush_i    = fl;
        @(negedge clk_i);
        ev = model_valid();
        sz = q.size();
        er = ((int'(DEPTH) - sz) >= int'(LANES)) && !fl;
        check("out_valid", 64'(out_valid_o), 64'(ev));
        check("in_ready", 64'(in_ready_o), 64'(er));
        if (tbl_chk) begin
            check("tbl_out_valid", 64'(out_valid_o), 64'(tbl_ev));
            check("tbl_in_ready", 64'(in_ready_o), 64'(tbl_er));
        end
        for (int k = 0; k < int'(LANES); k++) begin
            if (ev[k]) begin
                oe = out_entry_o[k*EW +: EW];
                check("lane_itag", 64'(oe.itag), 64'(q[k].itag));
                check("lane_data", oe.data, q[k].data);
            end
        end
        check("stall_cnt", stall_cnt_o, exp_stall());
        @(posedge clk_i);
        if (sz != 0 && !ev[0] && m_stall != '1) m_stall = m_stall + 64'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (wbv) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].itag == wbt) begin
                        r      = q[i];
                        r.done = 1'b1;
                        q[i]   = r;
                    end
                end
            end
            for (int i = 0; i < int'(pop); i++) void'(q.pop_front());
            if (inv[0] && er) begin
                for (int k = 0; k < int'(LANES); k++) begin
                    if (inv[k]) begin
                        r.itag = st_e[k].itag;
                        r.data = st_e[k].data;
                        r.solo = st_solo[k];
                        r.done = st_e[k].complete || (wbv && st_e[k].itag == wbt);
                        q.push_back(r);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic row(input logic [1:0] inv, input int t0, input int k0, input bit c0,
                       input int t1, input int k1, input bit c1, input logic wbv,
                       input logic [7:0] wbt, input logic [1:0] pop, input logic fl,
                       input logic [1:0] ev, input logic er);
        vec_t v;
        v = '{inv, t0, k0, c0, t1, k1, c1, wbv, wbt, pop, fl, ev, er};
        tbl.push_back(v);
    endtask

    logic [1:0]  r_inv, r_pop, r_ev;
    logic        r_wbv, r_fl;
    logic [7:0]  r_wbt, next_tag;
    logic [63:0] s0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_stall = '0;
        tbl_chk = 1'b0;
        tbl_ev  = '0;
        tbl_er  = 1'b0;
        st_e[0] = '0;
        st_e[1] = '0;
        arst_i     = 1'b1;
        flush_i    = 1'b0;
        in_valid_i = '0;
        in_entry_i = '0;
        wb_valid_i = 1'b0;
        wb_itag_i  = '0;
        out_pop_i  = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_stall", stall_cnt_o, 64'd0);
        arst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // inv  t0 k0 c0  t1 k1 c1 wbv wbt pop fl  ev er
        row(2'b11,  1, K_NONE, 1,  2, K_NONE, 1, 0, 0, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b00, 1);
        row(2'b11,  5, K_NONE, 0,  6, K_NONE, 0, 0, 0, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 1, 6, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 1, 5, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 1);
        row(2'b11,  7, K_ECALL,1,  8, K_NONE, 1, 0, 0, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 1, 0, 2'b01, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 1, 0, 2'b01, 1);
        row(2'b11,  9, K_NONE, 1, 10, K_MMIO, 1, 0, 0, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 1, 0, 2'b01, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 1, 0, 2'b01, 1);
        row(2'b11, 11, K_NONE, 0, 12, K_NONE, 0, 1,12, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 1,11, 0, 0, 2'b00, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 1);
        row(2'b11, 13, K_NONE, 1, 14, K_NONE, 1, 0, 0, 0, 0, 2'b00, 1);
        row(2'b11, 15, K_NONE, 1, 16, K_NONE, 1, 0, 0, 0, 0, 2'b11, 1);
        row(2'b01, 17, K_NONE, 1,  0, K_NONE, 0, 0, 0, 0, 0, 2'b11, 1);
        row(2'b11, 18, K_NONE, 1, 19, K_NONE, 1, 1,17, 1, 1, 2'b11, 0);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b00, 1);
        row(2'b11, 20, K_NONE, 1, 21, K_NONE, 1, 0, 0, 0, 0, 2'b00, 1);
        row(2'b11, 22, K_NONE, 1, 23, K_NONE, 1, 0, 0, 0, 0, 2'b11, 1);
        row(2'b11, 24, K_NONE, 1, 25, K_NONE, 1, 0, 0, 0, 0, 2'b11, 1);
        row(2'b01, 26, K_NONE, 1,  0, K_NONE, 0, 0, 0, 0, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b11, 0);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 1, 0, 2'b11, 0);
        row(2'b11, 27, K_NONE, 1, 28, K_NONE, 1, 0, 0, 0, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b11, 0);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 0);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 2, 0, 2'b11, 1);
        row(2'b00,  0, K_NONE, 0,  0, K_NONE, 0, 0, 0, 0, 0, 2'b00, 1);

        tbl_chk = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            mk(0, 8'(tbl[i].t0), tbl[i].k0, tbl[i].c0);
            mk(1, 8'(tbl[i].t1), tbl[i].k1, tbl[i].c1);
            tbl_ev = tbl[i].ev;
            tbl_er = tbl[i].er;
            cyc(tbl[i].inv, tbl[i].wbv, tbl[i].wbt, tbl[i].pop, tbl[i].fl);
        end
        tbl_chk = 1'b0;

        // One incomplete entry parked at the head for ten cycles.
        s0 = m_stall;
        mk(0, 8'd30, K_NONE, 1'b0);
        mk(1, 8'd31, K_NONE, 1'b0);
        cyc(2'b01, 1'b0, 8'd0, 2'd0, 1'b0);
        mk(0, 8'd0, K_NONE, 1'b0);
        mk(1, 8'd0, K_NONE, 1'b0);
        repeat (10) cyc(2'b00, 1'b0, 8'd0, 2'd0, 1'b0);
`ifdef ROBREAD_STALL_CNT_EN
        check("stall_hold10", stall_cnt_o, s0 + 64'd10);
`else
        check("stall_hold10", stall_cnt_o, 64'd0);
`endif
        cyc(2'b00, 1'b1, 8'd30, 2'd0, 1'b0);
        cyc(2'b00, 1'b0, 8'd0, 2'd1, 1'b0);

        next_tag = 8'd40;
        for (int it = 0; it < 800; it++) begin
            r_inv = 2'($urandom_range(0, 2));
            if (r_inv == 2'b10) r_inv = 2'b11;
            for (int k = 0; k < 2; k++) begin
                mk(k, next_tag, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10)) : K_NONE,
                   1'($urandom_range(0, 1)));
                next_tag = next_tag + 8'd1;
            end
            r_wbv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       r_wbt = st_e[$urandom_range(0, 1)].itag;
                1:       r_wbt = 8'($urandom);
                default: r_wbt = (q.size() != 0) ? q[$urandom_range(0, q.size() - 1)].itag : 8'($urandom);
            endcase
            r_ev  = model_valid();
            r_pop = 2'($urandom_range(0, $countones(r_ev)));
            r_fl  = ($urandom_range(0, 40) == 0);
            cyc(r_inv, r_wbv, r_wbt, r_pop, r_fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
